operand_loader: RTL and testbench

//  Upstream feeder for the multicycle add/sub datapath and its control unit.

---
 rtl/operand_loader.sv | 124 ++++++++++++
 tb/tb_operand_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Collects a four-word operand frame over a valid/ready stream, presents it to the
// multicycle add/sub control unit with a one-cycle start, then waits for done or a watchdog.
module operand_loader #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic             mode,
    output logic             start,
    input  logic             done,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] LAST_WORD = 2'(NUM_OPS - 1);
    localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic [7:0]       r_wd;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_op_c;
    logic [WIDTH-1:0] r_op_d;
    logic             r_mode;
    logic             r_start;
    logic             r_busy;
    logic             r_timeout;
    logic             w_xfer;

    // Ready is gated by reset so no word can slip in on a reset edge.
    assign in_ready = (r_state == S_LOAD) & ~reset;
    assign w_xfer   = in_valid & in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_LOAD;
            r_cnt     <= 2'd0;
            r_wd      <= 8'd0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_c    <= '0;
            r_op_d    <= '0;
            r_mode    <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_xfer) begin
                        case (r_cnt)
                            2'd0: begin
                                r_op_a <= in_data;
                                r_mode <= in_mode;
                            end
                            2'd1:    r_op_b <= in_data;
                            2'd2:    r_op_c <= in_data;
                            default: r_op_d <= in_data;
                        endcase
                        if (r_cnt == LAST_WORD) begin
                            r_cnt   <= 2'd0;
                            r_state <= S_ISSUE;
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wd    <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a watchdog expiry on the same edge.
                    if (done) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b0;
                    end else if (r_wd == WD_LAST) begin
                        r_state   <= S_LOAD;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_wd      <= 8'd0;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign op_c    = r_op_c;
    assign op_d    = r_op_d;
    assign mode    = r_mode;
    assign start   = r_start;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios plus randomized traffic against a
// frame-level reference model (words collected into an array, cycles counted since start).
module tb_operand_loader;

    localparam int W  = 8;
    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a, op_b, op_c, op_d;
    logic         mode, start, done = 1'b0, busy, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [W-1:0] m_op [4] = '{default: '0};
    logic         m_mode = 1'b0;
    int           m_n = 0;
    bit           m_busy = 1'b0;
    int           m_age = 0;
    bit           m_start = 1'b0;
    bit           m_timeout = 1'b0;

    operand_loader #(.WIDTH(W), .NUM_OPS(4), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .op_c(op_c), .op_d(op_d), .mode(mode), .start(start), .done(done),
        .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // One clock: advance the model with the inputs seen at the edge, settle 1ns after.
    task automatic cyc();
        @(posedge clock);
        m_start   = 1'b0;
        m_timeout = 1'b0;
        if (reset) begin
            m_op   = '{default: '0};
            m_mode = 1'b0;
            m_n    = 0;
            m_busy = 1'b0;
            m_age  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_op[m_n] = in_data;
                if (m_n == 0) m_mode = in_mode;
                m_n++;
                if (m_n == 4) begin
                    m_n     = 0;
                    m_busy  = 1'b1;
                    m_start = 1'b1;
                    m_age   = 0;
                end
            end
        end else if (m_age >= 1 && done) begin
            m_busy = 1'b0;
        end else if (m_age == TO) begin
            m_busy    = 1'b0;
            m_timeout = 1'b1;
        end else begin
            m_age++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] a, b, c, d, input logic md, input int maxgap);
        logic [W-1:0] w [4];
        w = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                cyc();
            end
            in_valid = 1'b1;
            in_data  = w[i];
            in_mode  = (i == 0) ? md : 1'($urandom);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_wait();
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 0", in_ready);
        end
        cyc();
        cyc();
        n_cmp++;
        if ({op_a, op_b, op_c, op_d, mode, start, busy, timeout, in_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h %h %h %h m%b s%b b%b t%b r%b want all 0",
                     op_a, op_b, op_c, op_d, mode, start, busy, timeout, in_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] w [4];
        int start_cyc;
        w = '{8'h03, 8'h01, 8'h05, 8'h04};
        start_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            in_mode  = 1'b0;
            cyc();
            if (start === 1'b1 && start_cyc == 0) start_cyc = i + 2;
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({op_a, op_b, op_c, op_d, mode} !== {8'h03, 8'h01, 8'h05, 8'h04, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_ops: got %h %h %h %h m%b want 03 01 05 04 m0", op_a, op_b, op_c, op_d, mode);
        end
        n_cmp++;
        if (start_cyc != 5 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_start: start cycle %0d busy %b ready %b want 5 1 0", start_cyc, busy, in_ready);
        end
        cyc();
        n_cmp++;
        if (start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_wait: start %b busy %b ready %b want 0 1 0", start, busy, in_ready);
        end
        repeat (3) cyc();
        finish_wait();
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done: busy %b ready %b timeout %b want 0 1 0", busy, in_ready, timeout);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] w [4];
        int starts, hs;
        bit early;
        w = '{8'h03, 8'h01, 8'h05, 8'h04};
        starts = 0;
        hs = 0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(3, 1)) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                cyc();
                if (start === 1'b1) early = 1'b1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            in_mode  = 1'b0;
            cyc();
            hs++;
            if (start === 1'b1) begin
                starts++;
                if (hs != 4) early = 1'b1;
            end
        end
        in_valid = 1'b0;
        repeat (3) begin
            cyc();
            if (start === 1'b1) starts++;
        end
        n_cmp++;
        if ({op_a, op_b, op_c, op_d, mode} !== {8'h03, 8'h01, 8'h05, 8'h04, 1'b0}) begin
            n_bad++;
            $display("FAIL gaps_ops: got %h %h %h %h m%b want 03 01 05 04 m0", op_a, op_b, op_c, op_d, mode);
        end
        n_cmp++;
        if (starts != 1 || early) begin
            n_bad++;
            $display("FAIL gaps_start: pulses %0d early %b want 1 0", starts, early);
        end
        finish_wait();
    endtask

    task automatic test_timeout();
        int bad_early;
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 0);
        bad_early = 0;
        for (int k = 1; k <= TO; k++) begin
            cyc();
            if (timeout !== 1'b0 || busy !== 1'b1) bad_early++;
        end
        n_cmp++;
        if (bad_early != 0) begin
            n_bad++;
            $display("FAIL timeout_early: %0d cycles with timeout or !busy, want 0", bad_early);
        end
        cyc();
        n_cmp++;
        if (timeout !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_expiry: timeout %b busy %b ready %b want 1 0 1", timeout, busy, in_ready);
        end
        n_cmp++;
        if ({op_a, op_b, op_c, op_d, mode} !== {8'h11, 8'h22, 8'h33, 8'h44, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_ops: got %h %h %h %h m%b want 11 22 33 44 m1", op_a, op_b, op_c, op_d, mode);
        end
        cyc();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse_width: got %b want 0", timeout);
        end
    endtask

    task automatic test_abort();
        int starts;
        starts = 0;
        in_valid = 1'b1; in_data = 8'h03; in_mode = 1'b0; cyc();
        in_data = 8'h01; cyc();
        in_valid = 1'b1; in_data = 8'h05; reset = 1'b1; cyc();
        reset = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if ({op_a, op_b, op_c, op_d, start, busy} !== '0) begin
            n_bad++;
            $display("FAIL abort_clear: got %h %h %h %h s%b b%b want all 0", op_a, op_b, op_c, op_d, start, busy);
        end
        in_valid = 1'b1; in_data = 8'h0A; in_mode = 1'b1; cyc();
        if (start === 1'b1) starts++;
        in_data = 8'h0B; in_mode = 1'b0; cyc();
        if (start === 1'b1) starts++;
        in_data = 8'h0C; cyc();
        if (start === 1'b1) starts++;
        in_data = 8'h0D; cyc();
        in_valid = 1'b0;
        n_cmp++;
        if (starts != 0 || start !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_start: early pulses %0d start %b want 0 1", starts, start);
        end
        n_cmp++;
        if ({op_a, op_b, op_c, op_d, mode} !== {8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_ops: got %h %h %h %h m%b want 0A 0B 0C 0D m1", op_a, op_b, op_c, op_d, mode);
        end
        finish_wait();
    endtask

    task automatic test_done_ignored();
        int wait_cycles;
        done = 1'b1;
        cyc();
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_load: ready %b busy %b want 1 0", in_ready, busy);
        end
        done = 1'b0;
        in_valid = 1'b1; in_data = 8'h21; in_mode = 1'b0; cyc();
        in_data = 8'h22; cyc();
        in_data = 8'h23; cyc();
        in_data = 8'h24; done = 1'b1; cyc();
        in_valid = 1'b0;
        cyc();  // done high through the ISSUE edge
        done = 1'b0;
        wait_cycles = 1;
        while (timeout !== 1'b1 && wait_cycles < 3 * TO) begin
            cyc();
            wait_cycles++;
        end
        n_cmp++;
        if (wait_cycles != TO + 1) begin
            n_bad++;
            $display("FAIL done_ignored_timeout: timeout after %0d cycles want %0d", wait_cycles, TO + 1);
        end
    endtask

    task automatic test_done_expiry();
        send_frame(8'h31, 8'h32, 8'h33, 8'h34, 1'b0, 0);
        repeat (TO) cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        n_cmp++;
        if (timeout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL coincide: timeout %b busy %b ready %b want 0 0 1", timeout, busy, in_ready);
        end
        send_frame(8'hFF, 8'h01, 8'h01, 8'h01, 1'b1, 1);
        n_cmp++;
        if ({op_a, op_b, op_c, op_d, mode, start} !== {8'hFF, 8'h01, 8'h01, 8'h01, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL coincide_next: got %h %h %h %h m%b s%b want FF 01 01 01 m1 s1",
                     op_a, op_b, op_c, op_d, mode, start);
        end
        finish_wait();
    endtask

    task automatic test_random();
        logic [4*W+5-1:0] got, exp;
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(199, 0) == 0);
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            in_mode  = 1'($urandom);
            done     = ($urandom_range(5, 0) == 0);
            cyc();
            got = {op_a, op_b, op_c, op_d, mode, start, busy, timeout, in_ready};
            exp = {m_op[0], m_op[1], m_op[2], m_op[3], m_mode, m_start, m_busy, m_timeout,
                   (!m_busy && !reset)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h want %h", i, got, exp);
            end
        end
        reset = 1'b0;
        in_valid = 1'b0;
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_timeout();
        test_abort();
        test_done_ignored();
        test_done_expiry();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
